// File: rtl/vhsam_pkg.sv
// vhsam_pkg: opcodes, FSM states and console select codes for the Very Half SAM CPU.
package vhsam_pkg;
  localparam logic [3:0] OP_SYS    = 4'h0;
  localparam logic [3:0] OP_BR     = 4'h1;
  localparam logic [3:0] OP_BRZ    = 4'h2;
  localparam logic [3:0] OP_BRP    = 4'h3;
  localparam logic [3:0] OP_BRN    = 4'h4;
  localparam logic [3:0] OP_BRIND  = 4'h5;
  localparam logic [3:0] OP_CLOAD  = 4'h6;
  localparam logic [3:0] OP_DLOAD  = 4'h7;
  localparam logic [3:0] OP_ILOAD  = 4'h8;
  localparam logic [3:0] OP_DSTORE = 4'h9;
  localparam logic [3:0] OP_ISTORE = 4'hA;
  localparam logic [3:0] OP_ADD    = 4'hB;
  localparam logic [3:0] OP_AND    = 4'hC;
  localparam logic [7:0] IR_HALT   = 8'h00;
  localparam logic [7:0] IR_NEG    = 8'h01;
  localparam logic [1:0] SEL_PC    = 2'b00;
  localparam logic [1:0] SEL_IREG  = 2'b01;
  localparam logic [1:0] SEL_ACC   = 2'b10;
  typedef enum logic [3:0] {
    IDLE, FETCH_A, FETCH_D, DECODE, IND_A, IND_D, MEM_A, MEM_D, HALT, PAUSED
  } state_t;
  function automatic logic [7:0] sext4(input logic [3:0] v);
    return {{4{v[3]}}, v};
  endfunction
endpackage

// File: rtl/vhsam_alu.sv
// vhsam_alu: combinational accumulator arithmetic and branch-condition evaluation.
module vhsam_alu
  import vhsam_pkg::*;
(
  input  logic [3:0] op,
  input  logic [3:0] n,
  input  logic [7:0] acc,
  input  logic [7:0] mem,
  output logic [7:0] imm,
  output logic [7:0] neg,
  output logic [7:0] sum,
  output logic [7:0] conj,
  output logic       taken
);
  assign imm   = sext4(n);
  assign neg   = 8'h00 - acc;
  assign sum   = acc + mem;
  assign conj  = acc & mem;
  assign taken = (op == OP_BR) || (op == OP_BRZ && acc == 8'h00) ||
                 (op == OP_BRP && !acc[7] && acc != 8'h00) || (op == OP_BRN && acc[7]);
endmodule

// File: rtl/very_half_sam_top.sv
// very_half_sam_top: 8-bit accumulator CPU with a multiplexed address/data memory bus.
// Defining VHSAM_PAUSE_EN lets the console pause input hold the CPU between instructions.
module very_half_sam_top
  import vhsam_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] Bus_Out,
  input  logic [7:0] Bus_In,
  output logic       En,
  output logic       Rw,
  output logic       ALE,
  input  logic       pause,
  input  logic [1:0] regSelect,
  output logic [7:0] dispReg
);
  state_t state, nxt;
  logic [7:0] pc, acc, ireg, iar, imm, neg, sum, conj;
  logic [3:0] op, n;
  logic taken, hold, is_ind, is_store, is_mem;
  assign op = ireg[7:4];
  assign n  = ireg[3:0];
`ifdef VHSAM_PAUSE_EN
  assign hold = pause;
`else
  assign hold = pause & 1'b0;
`endif
  assign is_ind   = op == OP_ILOAD || op == OP_ISTORE;
  assign is_store = op == OP_DSTORE || op == OP_ISTORE;
  assign is_mem   = is_ind || is_store || op == OP_BRIND || op == OP_DLOAD ||
                    op == OP_ADD || op == OP_AND;
  assign dispReg  = regSelect == SEL_PC ? pc : regSelect == SEL_IREG ? ireg :
                    regSelect == SEL_ACC ? acc : iar;
  vhsam_alu alu (
    .op(op), .n(n), .acc(acc), .mem(Bus_In),
    .imm(imm), .neg(neg), .sum(sum), .conj(conj), .taken(taken)
  );
  always_comb begin
    nxt = state;
    ALE = 1'b0;
    En = 1'b0;
    Rw = 1'b1;
    Bus_Out = 8'h00;
    case (state)
      IDLE: nxt = FETCH_A;
      FETCH_A: begin
        nxt = hold ? PAUSED : FETCH_D;
        ALE = !hold;
        En = !hold;
        Bus_Out = hold ? 8'h00 : pc;
      end
      FETCH_D: begin
        nxt = DECODE;
        En = 1'b1;
      end
      DECODE: nxt = ireg == IR_HALT ? HALT : is_ind ? IND_A : is_mem ? MEM_A : FETCH_A;
      IND_A: begin
        nxt = IND_D;
        ALE = 1'b1;
        En = 1'b1;
        Bus_Out = {4'h0, n};
      end
      IND_D: begin
        nxt = MEM_A;
        En = 1'b1;
      end
      // write cycles keep En low while the address is latched
      MEM_A: begin
        nxt = MEM_D;
        ALE = 1'b1;
        En = !is_store;
        Rw = !is_store;
        Bus_Out = is_ind ? iar : {4'h0, n};
      end
      MEM_D: begin
        nxt = FETCH_A;
        En = 1'b1;
        Rw = !is_store;
        Bus_Out = is_store ? acc : 8'h00;
      end
      PAUSED: nxt = hold ? PAUSED : FETCH_A;
      default: nxt = HALT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= 8'h00;
      acc <= 8'h00;
      ireg <= 8'h00;
      iar <= 8'h00;
    end else begin
      state <= nxt;
      case (state)
        FETCH_D: begin
          ireg <= Bus_In;
          pc <= pc + 8'd1;
        end
        DECODE: begin
          if (ireg == IR_NEG) acc <= neg;
          if (op == OP_CLOAD) acc <= imm;
          if (taken) pc <= pc + imm;
        end
        IND_D: iar <= Bus_In;
        MEM_D: begin
          if (op == OP_BRIND) pc <= Bus_In;
          if (op == OP_DLOAD || op == OP_ILOAD) acc <= Bus_In;
          if (op == OP_ADD) acc <= sum;
          if (op == OP_AND) acc <= conj;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_very_half_sam_top.sv
// tb_very_half_sam_top: directed and random-program checks of the CPU against an instruction-level model.
module tb_very_half_sam_top;
  logic clk = 1'b0, rst = 1'b1, pause = 1'b0, load = 1'b0;
  logic En, Rw, ALE;
  logic [7:0] Bus_Out, Bus_In, dispReg, alat = 8'h00;
  logic [1:0] regSelect = 2'b00;
  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic [7:0] mm [256];
  int passed = 0, total = 0, viol = 0;

  always #5 clk = ~clk;

  very_half_sam_top dut (
    .clk(clk), .rst(rst), .Bus_Out(Bus_Out), .Bus_In(Bus_In), .En(En), .Rw(Rw), .ALE(ALE),
    .pause(pause), .regSelect(regSelect), .dispReg(dispReg)
  );

  assign Bus_In = mem[alat];
  always @(posedge clk)
    if (load) mem <= img;
    else begin
      if (ALE) alat <= Bus_Out;
      if (En && !Rw) mem[alat] <= Bus_Out;
    end
  always @(negedge clk) if (ALE && En && !Rw) viol++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic start();
    rst = 1'b1;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    rst = 1'b0;
  endtask

  task automatic clear();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic rd(input logic [1:0] s, output logic [7:0] v);
    regSelect = s;
    #1;
    v = dispReg;
  endtask

  // instruction-level model: executes up to ninst instructions on mm
  task automatic model(input int ninst, output logic [7:0] mpc, output logic [7:0] macc,
                       output logic [7:0] mir, output logic [7:0] miar, output int cyc,
                       output bit halted);
    logic [7:0] se, a;
    mpc = 0; macc = 0; mir = 0; miar = 0; cyc = 0; halted = 0;
    for (int i = 0; i < ninst && !halted; i++) begin
      mir = mm[mpc];
      mpc = mpc + 8'd1;
      se = {{4{mir[3]}}, mir[3:0]};
      a = {4'h0, mir[3:0]};
      cyc += 3;
      case (mir[7:4])
        4'h0: begin halted = (mir == 8'h00); if (mir == 8'h01) macc = 8'h00 - macc; end
        4'h1: mpc = mpc + se;
        4'h2: if (macc == 0) mpc = mpc + se;
        4'h3: if ($signed(macc) > 0) mpc = mpc + se;
        4'h4: if ($signed(macc) < 0) mpc = mpc + se;
        4'h5: begin mpc = mm[a]; cyc += 2; end
        4'h6: macc = se;
        4'h7: begin macc = mm[a]; cyc += 2; end
        4'h8: begin miar = mm[a]; macc = mm[miar]; cyc += 4; end
        4'h9: begin mm[a] = macc; cyc += 2; end
        4'hA: begin miar = mm[a]; mm[miar] = macc; cyc += 4; end
        4'hB: begin macc = macc + mm[a]; cyc += 2; end
        4'hC: begin macc = macc & mm[a]; cyc += 2; end
        default: ;
      endcase
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] v, mpc, macc, mir, miar;
    int cyc, bad;
    bit halted;
    clear();
    #1;
    chk("rst_en", En, 1'b0);
    chk("rst_rw", Rw, 1'b1);
    chk("rst_ale", ALE, 1'b0);
    chk("rst_bus", Bus_Out, 8'h00);
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v);
      chk("rst_reg", v, 8'h00);
    end
    // cload 3, dstore 4, halt
    img[0] = 8'h63; img[1] = 8'h94; img[2] = 8'h00;
    start();
    step(12);
    chk("store_mem4", mem[4], 8'h03);
    rd(2'b10, v); chk("store_acc", v, 8'h03);
    rd(2'b00, v); chk("store_pc", v, 8'h03);
    bad = 0;
    repeat (5) begin step(1); if (En !== 1'b0) bad++; end
    chk("halt_en_low", bad, 0);
    // direct branches
    clear(); img[0] = 8'h17; img[8] = 8'h12;
    start();
    step(4);
    chk("br_ale", ALE, 1'b1); chk("br_addr", Bus_Out, 8'h08);
    step(3);
    chk("br2_addr", Bus_Out, 8'h0B);
    // cload negative, negate
    clear(); img[0] = 8'h6D; img[1] = 8'h01;
    start();
    step(4); rd(2'b10, v); chk("cload_neg", v, 8'hFD);
    step(3); rd(2'b10, v); chk("negate", v, 8'h03);
    // add overflow into sign bit, then brNeg taken
    clear(); img[0] = 8'h7A; img[1] = 8'hBB; img[2] = 8'h42; img[10] = 8'h7F; img[11] = 8'h01;
    start();
    step(11); rd(2'b10, v); chk("add_acc", v, 8'h80);
    step(3); rd(2'b00, v); chk("brneg_pc", v, 8'h05);
    chk("brneg_addr", Bus_Out, 8'h05);
    // brInd to FF, nop there, PC wraps
    clear(); img[0] = 8'h5E; img[14] = 8'hFF; img[255] = 8'h0D;
    start();
    step(9); rd(2'b00, v); chk("wrap_pc", v, 8'h00);
    chk("wrap_addr", Bus_Out, 8'h00);
    // indirect load / store
    clear(); img[0] = 8'h82; img[1] = 8'hAF; img[2] = 8'h05; img[5] = 8'hAA; img[15] = 8'h06;
    start();
    step(8); rd(2'b10, v); chk("iload_acc", v, 8'hAA);
    rd(2'b11, v); chk("iload_iar", v, 8'h05);
    step(7); chk("istore_mem", mem[6], 8'hAA);
    rd(2'b11, v); chk("istore_iar", v, 8'h06);
    // reset during write D-phase
    clear(); img[0] = 8'h65; img[1] = 8'h99;
    start();
    step(8);
    chk("wr_en", En, 1'b1); chk("wr_rw", Rw, 1'b0); chk("wr_data", Bus_Out, 8'h05);
    rst = 1'b1;
    #1;
    chk("abort_en", En, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_nowrite", mem[9], 8'h00);
    rd(2'b00, v); chk("abort_pc", v, 8'h00);
    chk("abort_idle", ALE, 1'b0);
    step(1);
    chk("refetch_ale", ALE, 1'b1); chk("refetch_addr", Bus_Out, 8'h00);
`ifdef VHSAM_PAUSE_EN
    clear(); img[0] = 8'h63; img[1] = 8'h01; img[2] = 8'h01;
    start();
    step(4);
    pause = 1'b1;
    #1;
    bad = 0;
    repeat (10) begin
      rd(2'b00, v); if (v !== 8'h01) bad++;
      rd(2'b10, v); if (v !== 8'h03) bad++;
      if (En !== 1'b0 || ALE !== 1'b0) bad++;
      step(1);
    end
    chk("pause_frozen", bad, 0);
    pause = 1'b0;
    step(14);
    rd(2'b10, v); chk("pause_acc", v, 8'h03);
    rd(2'b00, v); chk("pause_pc", v, 8'h04);
`endif
    // random programs against the instruction-level model
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 256; i++) begin img[i] = 8'($urandom); mm[i] = img[i]; end
      start();
      model(25, mpc, macc, mir, miar, cyc, halted);
      step(1 + cyc);
      rd(2'b00, v); chk("rnd_pc", v, mpc);
      rd(2'b10, v); chk("rnd_acc", v, macc);
      rd(2'b01, v); chk("rnd_ireg", v, mir);
      rd(2'b11, v); chk("rnd_iar", v, miar);
      chk("rnd_bus", Bus_Out, halted ? 8'h00 : mpc);
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) bad++;
      chk("rnd_mem", bad, 0);
    end
    chk("ale_write_overlap", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
